// File: rtl/countdown_timer.sv
// Preloadable down-counter: counts a loaded value to expiry, with optional auto-reload for periodic ticks.
// All outputs registered; tick fires one cycle after an enabled count of 1 is consumed.
module countdown_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] v,
   input  logic             en,
   input  logic             stop,
   input  logic             auto,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tick
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state;
   logic [WIDTH-1:0] reload;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         count  <= '0;
         reload <= '0;
         busy   <= 1'b0;
         tick   <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else if (ld) begin
            count  <= v;
            reload <= v;
            if (v != '0) begin
               state <= RUN;
               busy  <= 1'b1;
            end else begin
               // a zero load is an immediate expiry
               state <= IDLE;
               busy  <= 1'b0;
               tick  <= 1'b1;
            end
         end else if (state == RUN && en) begin
            if (count > ONE) begin
               count <= count - ONE;
            end else begin
               tick <= 1'b1;
               if (auto) begin
                  count <= reload;
               end else begin
                  count <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed test-plan scenarios plus a randomized run against a reference model.
module tb_countdown_timer;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             ld, en, stop, auto;
   logic [WIDTH-1:0] v;
   logic [WIDTH-1:0] count;
   logic             busy, tick;

   int errors = 0;
   int checks = 0;

   countdown_timer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .ld(ld), .v(v), .en(en), .stop(stop),
      .auto(auto), .count(count), .busy(busy), .tick(tick)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // Apply inputs, take one rising edge, return 1 time unit later.
   task automatic drive(input logic l, input logic [WIDTH-1:0] val, input logic e,
                        input logic s, input logic a);
      ld = l; v = val; en = e; stop = s; auto = a;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      ld = 0; v = 0; en = 0; stop = 0; auto = 0; rst = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({count, busy, tick} !== '0)
         begin errors++; $display("FAIL reset_hold count=%0d busy=%b tick=%b expected 0/0/0", count, busy, tick); end
      rst = 1;
      drive(0, 0, 1, 0, 0);
      checks++;
      if ({count, busy, tick} !== '0)
         begin errors++; $display("FAIL reset_release count=%0d busy=%b tick=%b expected 0/0/0", count, busy, tick); end
   endtask

   task automatic test_oneshot;
      int ec[4] = '{3, 2, 1, 0};
      bit eb[4] = '{1, 1, 1, 0};
      bit et[4] = '{0, 0, 0, 1};
      drive(1, 3, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) drive(0, 0, 1, 0, 0);
         checks++;
         if (count !== WIDTH'(ec[i]) || busy !== eb[i] || tick !== et[i])
            begin errors++; $display("FAIL oneshot[%0d] count=%0d busy=%b tick=%b expected %0d/%b/%b", i, count, busy, tick, ec[i], eb[i], et[i]); end
      end
   endtask

   task automatic test_enable_gating;
      bit en_pat[6] = '{1, 0, 0, 1, 1, 1};
      int ec[6]     = '{3, 3, 3, 2, 1, 0};
      drive(1, 4, 0, 0, 0);
      checks++;
      if (count !== 4 || busy !== 1 || tick !== 0)
         begin errors++; $display("FAIL gating_load count=%0d busy=%b tick=%b expected 4/1/0", count, busy, tick); end
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, en_pat[i], 0, 0);
         checks++;
         if (count !== WIDTH'(ec[i]) || busy !== (i != 5) || tick !== (i == 5))
            begin errors++; $display("FAIL gating[%0d] count=%0d busy=%b tick=%b expected %0d/%b/%b", i, count, busy, tick, ec[i], i != 5, i == 5); end
      end
   endtask

   task automatic test_auto_reload;
      int pulses = 0;
      drive(1, 2, 1, 0, 1);
      checks++;
      if (count !== 2 || busy !== 1 || tick !== 0)
         begin errors++; $display("FAIL auto_load count=%0d busy=%b tick=%b expected 2/1/0", count, busy, tick); end
      for (int i = 1; i < 8; i++) begin
         drive(0, 0, 1, 0, 1);
         if (tick) pulses++;
         checks++;
         if (count !== ((i % 2 == 0) ? 2 : 1) || busy !== 1 || tick !== (i % 2 == 0))
            begin errors++; $display("FAIL auto[%0d] count=%0d busy=%b tick=%b expected %0d/1/%b", i, count, busy, tick, (i % 2 == 0) ? 2 : 1, i % 2 == 0); end
      end
      checks++;
      if (pulses != 3)
         begin errors++; $display("FAIL auto_pulses got %0d expected 3", pulses); end
      drive(0, 0, 1, 1, 0);
      checks++;
      if (count !== 1 || busy !== 0 || tick !== 0)
         begin errors++; $display("FAIL auto_stop count=%0d busy=%b tick=%b expected 1/0/0", count, busy, tick); end
   endtask

   task automatic test_zero_and_max;
      int n = 0;
      bit bad = 0;
      bit seen = 0;
      drive(1, 0, 1, 0, 0);
      checks++;
      if (count !== 0 || busy !== 0 || tick !== 1)
         begin errors++; $display("FAIL zero_load count=%0d busy=%b tick=%b expected 0/0/1", count, busy, tick); end
      drive(1, 255, 1, 0, 0);
      checks++;
      if (count !== 255 || busy !== 1 || tick !== 0)
         begin errors++; $display("FAIL max_load count=%0d busy=%b tick=%b expected 255/1/0", count, busy, tick); end
      while (n < 300 && !seen) begin
         drive(0, 0, 1, 0, 0);
         n++;
         seen = tick;
         if (!seen && (count !== WIDTH'(255 - n) || busy !== 1)) bad = 1;
      end
      checks++;
      if (!seen || n != 255)
         begin errors++; $display("FAIL max_latency tick_seen=%b after %0d cycles expected 255", seen, n); end
      checks++;
      if (count !== 0 || busy !== 0)
         begin errors++; $display("FAIL max_expiry count=%0d busy=%b expected 0/0", count, busy); end
      checks++;
      if (bad)
         begin errors++; $display("FAIL max_sequence count wrapped or skipped, flag=%b expected 0", bad); end
   endtask

   task automatic test_priority_restart;
      drive(1, 7, 1, 0, 0);
      repeat (2) drive(0, 0, 1, 0, 0);
      checks++;
      if (count !== 5 || busy !== 1)
         begin errors++; $display("FAIL prio_mid count=%0d busy=%b expected 5/1", count, busy); end
      drive(1, 9, 1, 0, 0);
      checks++;
      if (count !== 9 || busy !== 1 || tick !== 0)
         begin errors++; $display("FAIL prio_restart count=%0d busy=%b tick=%b expected 9/1/0", count, busy, tick); end
      drive(1, 3, 1, 1, 0);
      checks++;
      if (count !== 9 || busy !== 0 || tick !== 0)
         begin errors++; $display("FAIL prio_stop count=%0d busy=%b tick=%b expected 9/0/0", count, busy, tick); end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 0, 0);
         checks++;
         if (count !== 9 || busy !== 0 || tick !== 0)
            begin errors++; $display("FAIL prio_idle[%0d] count=%0d busy=%b tick=%b expected 9/0/0", i, count, busy, tick); end
      end
   endtask

   task automatic test_async_reset;
      drive(1, 6, 1, 0, 0);
      repeat (2) drive(0, 0, 1, 0, 0);
      checks++;
      if (count !== 4 || busy !== 1)
         begin errors++; $display("FAIL areset_pre count=%0d busy=%b expected 4/1", count, busy); end
      #2 rst = 0;
      #1;
      checks++;
      if (count !== 0 || busy !== 0 || tick !== 0)
         begin errors++; $display("FAIL areset_now count=%0d busy=%b tick=%b expected 0/0/0", count, busy, tick); end
      @(posedge clk);
      #1 rst = 1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 0, 1);
         checks++;
         if (count !== 0 || busy !== 0 || tick !== 0)
            begin errors++; $display("FAIL areset_idle[%0d] count=%0d busy=%b tick=%b expected 0/0/0", i, count, busy, tick); end
      end
      drive(1, 5, 1, 0, 0);
      checks++;
      if (count !== 5 || busy !== 1)
         begin errors++; $display("FAIL areset_reload count=%0d busy=%b expected 5/1", count, busy); end
   endtask

   // Reference model: timer described by its value, stored period and running flag.
   task automatic test_random;
      int  m_count = 0;
      int  m_period = 0;
      bit  m_running = 0;
      bit  m_tick;
      logic             r_ld, r_en, r_stop, r_auto;
      logic [WIDTH-1:0] r_v;
      rst = 0;
      @(posedge clk);
      #1 rst = 1;
      for (int i = 0; i < 400; i++) begin
         r_ld   = ($urandom_range(0, 7) == 0);
         r_stop = ($urandom_range(0, 15) == 0);
         r_en   = ($urandom_range(0, 3) != 0);
         r_auto = $urandom_range(0, 1);
         r_v    = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 255)) : WIDTH'($urandom_range(0, 6));
         drive(r_ld, r_v, r_en, r_stop, r_auto);
         m_tick = 0;
         if (r_stop) begin
            m_running = 0;
         end else if (r_ld) begin
            m_count   = int'(r_v);
            m_period  = int'(r_v);
            m_running = (r_v != 0);
            m_tick    = (r_v == 0);
         end else if (m_running && r_en) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
               m_tick = 1;
               if (r_auto) m_count = m_period;
               else m_running = 0;
            end
         end
         checks++;
         if (count !== WIDTH'(m_count) || busy !== m_running || tick !== m_tick)
            begin errors++; $display("FAIL random[%0d] count=%0d busy=%b tick=%b expected %0d/%b/%b", i, count, busy, tick, m_count, m_running, m_tick); end
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_enable_gating();
      test_auto_reload();
      test_zero_and_max();
      test_priority_restart();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
